// File: rtl/timer_pkg.sv
// Shared types and helpers for the microwave countdown timer.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      RUNNING,
      DONE
   } timer_state_t;

   localparam logic [3:0] BCD_ZERO = 4'd0;
   localparam logic [3:0] BCD_NINE = 4'd9;

   function automatic logic [3:0] bcd_clamp(input logic [3:0] value, input logic [3:0] max);
      return (value > max) ? max : value;
   endfunction

endpackage

// File: rtl/timer_countdown_if.sv
// Digit/load bundle from the keypad entry stage to the countdown engine.
interface timer_countdown_if;

   logic       loadn;
   logic [3:0] units_of_seconds;
   logic [3:0] tens_of_seconds;
   logic [3:0] units_of_minutes;

   modport master (
      output loadn,
      output units_of_seconds,
      output tens_of_seconds,
      output units_of_minutes
   );

   modport slave (
      input loadn,
      input units_of_seconds,
      input tens_of_seconds,
      input units_of_minutes
   );

endinterface

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit: clear > load (clamped) > decrement.
module bcd_digit_down
   import timer_pkg::*;
#(
   parameter logic [3:0] MAX = BCD_NINE
) (
   input  logic       clk,
   input  logic       clearn,
   input  logic       load,
   input  logic [3:0] din,
   input  logic       dec,
   output logic [3:0] q,
   output logic       borrow_out,
   output logic       is_zero
);

   always_ff @(posedge clk) begin
      if (!clearn) begin
         q <= BCD_ZERO;
      end else if (load) begin
         q <= bcd_clamp(din, MAX);
      end else if (dec) begin
         q <= (q == BCD_ZERO) ? MAX : q - 4'd1;
      end
   end

   assign is_zero    = (q == BCD_ZERO);
   assign borrow_out = dec & is_zero;

endmodule

// File: rtl/timer_countdown.sv
// Countdown engine: loads M:SS BCD digits and counts down one second per pgt_1Hz rising edge.
module timer_countdown
   import timer_pkg::*;
#(
   parameter logic [3:0] MAX_SEC_TENS = 4'd5,
   parameter logic [3:0] MAX_DIGIT    = BCD_NINE
) (
   input  logic                clk,
   input  logic                clearn,
   timer_countdown_if.slave    kp,
   input  logic                pgt_1Hz,
   input  logic                en,
   output logic [3:0]          sec_ones,
   output logic [3:0]          sec_tens,
   output logic [3:0]          min_ones,
   output logic                zero,
   output logic                done,
   output logic                running
);

   timer_state_t state_q, state_d;
   logic         p_q;
   logic         done_q, done_d;
   logic         tick;
   logic         load;
   logic         load_nonzero;
   logic         dec_en;
   logic         last_dec;
   logic         ones_zero, tens_zero, min_zero;
   logic         ones_borrow, tens_borrow;
   logic         unused_min_borrow;

   assign tick = pgt_1Hz & ~p_q;
   assign load = ~kp.loadn;

   assign load_nonzero = |{bcd_clamp(kp.units_of_seconds, MAX_DIGIT),
                           bcd_clamp(kp.tens_of_seconds, MAX_SEC_TENS),
                           bcd_clamp(kp.units_of_minutes, MAX_DIGIT)};

   // Decrement only while running with en held; a load in the same cycle wins.
   assign dec_en   = (state_q == RUNNING) & en & tick & ~load & ~zero;
   assign last_dec = dec_en & (sec_ones == 4'd1) & tens_zero & min_zero;

   bcd_digit_down #(.MAX(MAX_DIGIT)) u_sec_ones (
      .clk        (clk),
      .clearn     (clearn),
      .load       (load),
      .din        (kp.units_of_seconds),
      .dec        (dec_en),
      .q          (sec_ones),
      .borrow_out (ones_borrow),
      .is_zero    (ones_zero)
   );

   bcd_digit_down #(.MAX(MAX_SEC_TENS)) u_sec_tens (
      .clk        (clk),
      .clearn     (clearn),
      .load       (load),
      .din        (kp.tens_of_seconds),
      .dec        (ones_borrow),
      .q          (sec_tens),
      .borrow_out (tens_borrow),
      .is_zero    (tens_zero)
   );

   bcd_digit_down #(.MAX(MAX_DIGIT)) u_min_ones (
      .clk        (clk),
      .clearn     (clearn),
      .load       (load),
      .din        (kp.units_of_minutes),
      .dec        (tens_borrow),
      .q          (min_ones),
      .borrow_out (unused_min_borrow),
      .is_zero    (min_zero)
   );

   always_ff @(posedge clk) begin
      if (!clearn) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
         p_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         p_q     <= pgt_1Hz;
      end
   end

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      if (load) begin
         state_d = load_nonzero ? ARMED : IDLE;
      end else begin
         unique case (state_q)
            IDLE:    state_d = IDLE;
            ARMED:   if (en) state_d = RUNNING;
            RUNNING: begin
               if (!en) begin
                  state_d = ARMED;
               end else if (last_dec) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
         endcase
      end
   end

   assign zero    = ones_zero & tens_zero & min_zero;
   assign done    = done_q;
   assign running = (state_q == RUNNING);

endmodule

// File: tb/tb_timer_countdown.sv
// Directed self-checking bench for timer_countdown: vector table plus multi-cycle sequences.
module tb_timer_countdown;

   logic       clk = 1'b0;
   logic       clearn;
   logic       pgt_1Hz;
   logic       en;
   logic [3:0] sec_ones, sec_tens, min_ones;
   logic       zero, done, running;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   timer_countdown_if kp();

   timer_countdown #(.MAX_SEC_TENS(4'd5), .MAX_DIGIT(4'd9)) dut (
      .clk      (clk),
      .clearn   (clearn),
      .kp       (kp),
      .pgt_1Hz  (pgt_1Hz),
      .en       (en),
      .sec_ones (sec_ones),
      .sec_tens (sec_tens),
      .min_ones (min_ones),
      .zero     (zero),
      .done     (done),
      .running  (running)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       loadn;
      logic [3:0] mi, te, un;
      logic       en, pgt;
      logic [3:0] em, et, eu;
      logic       ez, ed, er;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic ld, input logic [3:0] mi, input logic [3:0] te,
                               input logic [3:0] un, input logic e, input logic p,
                               input logic [3:0] em, input logic [3:0] et, input logic [3:0] eu,
                               input logic ez, input logic ed, input logic er);
      vec_t v;
      v.loadn = ld; v.mi = mi; v.te = te; v.un = un; v.en = e; v.pgt = p;
      v.em = em; v.et = et; v.eu = eu; v.ez = ez; v.ed = ed; v.er = er;
      return v;
   endfunction

   function automatic logic [14:0] pack(input logic [3:0] m, input logic [3:0] t, input logic [3:0] s,
                                        input logic z, input logic d, input logic r);
      return {m, t, s, z, d, r};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [14:0] exp);
      logic [14:0] got;
      got = {min_ones, sec_tens, sec_ones, zero, done, running};
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d:%0d%0d z=%b d=%b r=%b, want %0d:%0d%0d z=%b d=%b r=%b",
                  name, got[14:11], got[10:7], got[6:3], got[2], got[1], got[0],
                  exp[14:11], exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic set_load(input logic ld, input logic [3:0] m, input logic [3:0] t, input logic [3:0] s);
      kp.loadn            = ld;
      kp.units_of_minutes = m;
      kp.tens_of_seconds  = t;
      kp.units_of_seconds = s;
   endtask

   initial begin
      int secs;
      // reset with inputs 1:23 and loadn high
      clearn = 1'b0; en = 1'b0; pgt_1Hz = 1'b0;
      set_load(1'b1, 4'd1, 4'd2, 4'd3);
      step();
      check("reset", pack(0, 0, 0, 1, 0, 0));
      clearn = 1'b1; en = 1'b1; pgt_1Hz = 1'b1;
      step();
      check("idle_tick", pack(0, 0, 0, 1, 0, 0));
      pgt_1Hz = 1'b0; en = 1'b0;
      step();

      //          ld  mi  te  un  en pgt   em  et  eu  z  d  r
      tbl.push_back(mk(0, 1, 0, 0,  0, 0,   1, 0, 0,  0, 0, 0)); // load 1:00
      tbl.push_back(mk(1, 0, 0, 0,  1, 0,   1, 0, 0,  0, 0, 1)); // start
      tbl.push_back(mk(1, 0, 0, 0,  1, 1,   0, 5, 9,  0, 0, 1)); // tick, double borrow
      tbl.push_back(mk(1, 0, 0, 0,  1, 1,   0, 5, 9,  0, 0, 1)); // held high
      tbl.push_back(mk(1, 0, 0, 0,  1, 0,   0, 5, 9,  0, 0, 1));
      tbl.push_back(mk(0, 0, 7, 12, 1, 0,   0, 5, 9,  0, 0, 0)); // clamp 0:7(12)
      tbl.push_back(mk(0, 0, 0, 2,  0, 0,   0, 0, 2,  0, 0, 0)); // load 0:02
      tbl.push_back(mk(1, 0, 0, 0,  1, 0,   0, 0, 2,  0, 0, 1));
      tbl.push_back(mk(1, 0, 0, 0,  1, 1,   0, 0, 1,  0, 0, 1));
      tbl.push_back(mk(1, 0, 0, 0,  1, 0,   0, 0, 1,  0, 0, 1));
      tbl.push_back(mk(1, 0, 0, 0,  1, 1,   0, 0, 0,  1, 1, 0)); // reach 0:00
      tbl.push_back(mk(1, 0, 0, 0,  1, 1,   0, 0, 0,  1, 0, 0)); // done drops
      tbl.push_back(mk(1, 0, 0, 0,  1, 0,   0, 0, 0,  1, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0,  1, 1,   0, 0, 0,  1, 0, 0)); // tick in DONE
      tbl.push_back(mk(0, 0, 0, 0,  0, 0,   0, 0, 0,  1, 0, 0)); // load 0:00
      tbl.push_back(mk(1, 0, 0, 0,  1, 0,   0, 0, 0,  1, 0, 0)); // en in IDLE
      tbl.push_back(mk(1, 0, 0, 0,  1, 1,   0, 0, 0,  1, 0, 0));
      tbl.push_back(mk(0, 9, 5, 9,  0, 0,   9, 5, 9,  0, 0, 0)); // load 9:59
      tbl.push_back(mk(0, 15, 15, 15, 0, 0, 9, 5, 9,  0, 0, 0)); // clamp all
      tbl.push_back(mk(0, 0, 1, 0,  0, 1,   0, 1, 0,  0, 0, 0)); // load 0:10, pgt high
      tbl.push_back(mk(1, 0, 0, 0,  1, 1,   0, 1, 0,  0, 0, 1)); // no tick on loadn rise
      tbl.push_back(mk(1, 0, 0, 0,  1, 1,   0, 1, 0,  0, 0, 1));
      tbl.push_back(mk(1, 0, 0, 0,  1, 0,   0, 1, 0,  0, 0, 1));
      tbl.push_back(mk(1, 0, 0, 0,  1, 1,   0, 0, 9,  0, 0, 1)); // tens borrow

      for (int i = 0; i < tbl.size(); i++) begin
         set_load(tbl[i].loadn, tbl[i].mi, tbl[i].te, tbl[i].un);
         en      = tbl[i].en;
         pgt_1Hz = tbl[i].pgt;
         step();
         check($sformatf("vec%0d", i),
               pack(tbl[i].em, tbl[i].et, tbl[i].eu, tbl[i].ez, tbl[i].ed, tbl[i].er));
      end

      // full count from 1:00
      set_load(1'b0, 4'd1, 4'd0, 4'd0); en = 1'b0; pgt_1Hz = 1'b0;
      step();
      kp.loadn = 1'b1; en = 1'b1;
      step();
      for (int k = 1; k <= 60; k++) begin
         pgt_1Hz = 1'b1;
         step();
         secs = 60 - k;
         check($sformatf("count_%0d", k),
               pack(4'(secs / 60), 4'((secs % 60) / 10), 4'(secs % 10),
                    k == 60, k == 60, k != 60));
         pgt_1Hz = 1'b0;
         step();
      end
      check("done_hold", pack(0, 0, 0, 1, 0, 0));

      // pause and resume
      set_load(1'b0, 4'd0, 4'd0, 4'd5); en = 1'b0;
      step();
      kp.loadn = 1'b1; en = 1'b1;
      step();
      for (int k = 0; k < 2; k++) begin
         pgt_1Hz = 1'b1; step(); pgt_1Hz = 1'b0; step();
      end
      check("two_ticks", pack(0, 0, 3, 0, 0, 1));
      en = 1'b0;
      step();
      check("paused", pack(0, 0, 3, 0, 0, 0));
      for (int k = 0; k < 3; k++) begin
         pgt_1Hz = 1'b1; step(); pgt_1Hz = 1'b0; step();
      end
      check("paused_ticks", pack(0, 0, 3, 0, 0, 0));
      en = 1'b1;
      step();
      check("resumed", pack(0, 0, 3, 0, 0, 1));
      pgt_1Hz = 1'b1;
      for (int k = 0; k < 20; k++) step();
      pgt_1Hz = 1'b0;
      step();
      check("long_high", pack(0, 0, 2, 0, 0, 1));
      en = 1'b0; pgt_1Hz = 1'b1;
      step();
      check("en_drop_tick", pack(0, 0, 2, 0, 0, 0));
      pgt_1Hz = 1'b0;
      step();

      // load abort while running, with a coincident tick
      set_load(1'b0, 4'd0, 4'd1, 4'd0);
      step();
      kp.loadn = 1'b1; en = 1'b1;
      step();
      check("run_010", pack(0, 1, 0, 0, 0, 1));
      set_load(1'b0, 4'd0, 4'd3, 4'd0); pgt_1Hz = 1'b1;
      step();
      check("abort_load", pack(0, 3, 0, 0, 0, 0));
      kp.loadn = 1'b1; en = 1'b0; pgt_1Hz = 1'b0;
      step();
      check("abort_armed", pack(0, 3, 0, 0, 0, 0));

      // reset mid-count
      en = 1'b1;
      step();
      pgt_1Hz = 1'b1;
      step();
      check("pre_reset", pack(0, 2, 9, 0, 0, 1));
      pgt_1Hz = 1'b0;
      step();
      clearn = 1'b0; pgt_1Hz = 1'b1;
      step();
      check("mid_reset", pack(0, 0, 0, 1, 0, 0));
      clearn = 1'b1; pgt_1Hz = 1'b0;
      step();
      check("post_reset", pack(0, 0, 0, 1, 0, 0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
